ysyx_25040109_mem_arbiter: RTL

- Shares the single physical memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Sits between IFU/LSU and the memory model.
- Handles one transaction at a time, with valid/ready request handshakes and single-cycle response pulses.
- Uses round-robin arbitration on conflict, a response timeout, and write-length checking.

---
 rtl/ysyx_25040109_mem_pkg.sv | 30 +++
 rtl/ysyx_25040109_rr_arb2.sv | 32 +++
 rtl/ysyx_25040109_mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ysyx_25040109_mem_pkg.sv
// Shared types and encodings for the IFU/LSU memory-port arbiter.
// Imported by the arbiter top and its round-robin sub-block.
package ysyx_25040109_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [2:0] WLEN_B = 3'b001;
  localparam logic [2:0] WLEN_H = 3'b010;
  localparam logic [2:0] WLEN_W = 3'b100;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [2:0]  wlen;
  } mreq_t;

  function automatic logic wlen_ok(input logic [2:0] w);
    return (w == WLEN_B) || (w == WLEN_H) || (w == WLEN_W);
  endfunction

endpackage

// File: rtl/ysyx_25040109_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is IFU, bit 1 is LSU.
// On a tie the requester that did not win last time is granted.
module ysyx_25040109_rr_arb2
  import ysyx_25040109_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    grant  = 2'b00;
    winner = OWN_IFU;
    unique case (req)
      2'b01: begin
        grant  = 2'b01;
        winner = OWN_IFU;
      end
      2'b10: begin
        grant  = 2'b10;
        winner = OWN_LSU;
      end
      2'b11: begin
        winner = ~last;
        grant  = winner ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25040109_mem_arbiter.sv
// Single-port memory arbiter between IFU and LSU: one transaction
// in flight, round-robin on conflict, timeout and write-length check.
module ysyx_25040109_mem_arbiter
  import ysyx_25040109_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [2:0]  lsu_wlen,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_wlen,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_t      state;
  state_t      state_nx;
  logic        owner;
  logic        rr_last;
  mreq_t       q;
  logic [CNT_W-1:0] cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  grant;
  logic        winner;
  logic        accept;
  logic        done;
  logic        tmo;
  logic        bad_len;
  logic        last_cyc;

  ysyx_25040109_rr_arb2 u_arb (
    .req    ({lsu_req_valid, ifu_req_valid}),
    .last   (rr_last),
    .grant  (grant),
    .winner (winner)
  );

  assign bad_len  = (winner == OWN_LSU) && lsu_wen && !wlen_ok(lsu_wlen);
  assign last_cyc = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|grant) begin
          accept   = 1'b1;
          state_nx = bad_len ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready && mem_resp_valid) begin
          done     = 1'b1;
          state_nx = S_RESP;
        end else if (last_cyc) begin
          tmo      = 1'b1;
          state_nx = S_RESP;
        end else if (mem_req_ready) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          done     = 1'b1;
          state_nx = S_RESP;
        end else if (last_cyc) begin
          tmo      = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      owner   <= OWN_IFU;
      rr_last <= OWN_LSU;
      q       <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner   <= winner;
        rr_last <= winner;
        cnt     <= '0;
        rdata_q <= '0;
        err_q   <= bad_len;
        if (winner == OWN_LSU)
          q <= '{lsu_addr, lsu_wen, lsu_wdata, lsu_wlen};
        else
          q <= '{ifu_addr, 1'b0, 32'h0, 3'b000};
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (done) begin
        rdata_q <= q.wen ? 32'h0 : mem_rdata;
        err_q   <= 1'b0;
      end else if (tmo) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Ready is gated by reset so nothing is offered while held in reset.
  assign ifu_req_ready = rst && (state == S_IDLE) && grant[0];
  assign lsu_req_ready = rst && (state == S_IDLE) && grant[1];

  assign mem_req_valid = (state == S_REQ);
  assign mem_addr      = q.addr;
  assign mem_wen       = q.wen;
  assign mem_wdata     = q.wdata;
  assign mem_wlen      = q.wlen;

  assign ifu_resp_valid = (state == S_RESP) && (owner == OWN_IFU);
  assign lsu_resp_valid = (state == S_RESP) && (owner == OWN_LSU);
  assign ifu_rdata      = ifu_resp_valid ? rdata_q : 32'h0;
  assign lsu_rdata      = lsu_resp_valid ? rdata_q : 32'h0;
  assign ifu_resp_err   = ifu_resp_valid && err_q;
  assign lsu_resp_err   = lsu_resp_valid && err_q;

  assign busy = (state != S_IDLE);

endmodule
